// File: rtl/bomb_fuse_if.sv
// bomb_fuse bus: bomb/player positions in, explode request
// and blast geometry out.
interface bomb_fuse_if;
   logic       bomb_check;
   logic [9:0] bombX;
   logic [9:0] bombY;
   logic [9:0] playerX;
   logic [9:0] playerY;
   logic       explode;
   logic       blast_active;
   logic [9:0] blastXL;
   logic [9:0] blastXR;
   logic [9:0] blastYT;
   logic [9:0] blastYB;
   logic [9:0] blastBoxXL;
   logic [9:0] blastBoxXR;
   logic [9:0] blastBoxYT;
   logic [9:0] blastBoxYB;
   logic       player_hit;

   modport master (
      output bomb_check, bombX, bombY,
      output playerX, playerY,
      input  explode, blast_active, player_hit,
      input  blastXL, blastXR, blastYT, blastYB,
      input  blastBoxXL, blastBoxXR,
      input  blastBoxYT, blastBoxYB
   );

   modport slave (
      input  bomb_check, bombX, bombY,
      input  playerX, playerY,
      output explode, blast_active, player_hit,
      output blastXL, blastXR, blastYT, blastYB,
      output blastBoxXL, blastBoxXR,
      output blastBoxYT, blastBoxYB
   );
endinterface

// File: rtl/bomb_fuse.sv
// Bomb fuse timer, explode handshake and cross-shaped
// blast geometry with player hit detection.
module bomb_fuse #(
   parameter int FUSE_FRAMES  = 120,
   parameter int BLAST_FRAMES = 30,
   parameter int BLAST_REACH  = 48,
   parameter int BOMB_W       = 20,
   parameter int BOMB_H       = 25,
   parameter int PLAYER_S     = 16
) (
   input  logic       frame_clk,
   input  logic       Reset,
   bomb_fuse_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, FUSE, FIRE, BLAST
   } state_t;

   localparam logic [7:0] FUSE_LAST =
      8'(FUSE_FRAMES - 1);
   localparam logic [7:0] BLAST_LAST =
      8'(BLAST_FRAMES - 1);
   localparam logic [10:0] REACH = 11'(BLAST_REACH);
   localparam logic [10:0] W_M1  = 11'(BOMB_W - 1);
   localparam logic [10:0] H_M1  = 11'(BOMB_H - 1);
   localparam logic [10:0] S_M1  = 11'(PLAYER_S - 1);
   localparam logic [10:0] X_MAX = 11'd639;
   localparam logic [10:0] Y_MAX = 11'd479;

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       latch;

   logic [9:0] xl_q, xr_q, yt_q, yb_q;
   logic [9:0] bxl_q, bxr_q, byt_q, byb_q;
   logic       hit_q, hit_nx;

   logic [10:0] bx, by, bx_end, by_end;
   logic [10:0] bx_far, by_far;
   logic [9:0]  xl_c, xr_c, yt_c, yb_c;
   logic [9:0]  bxr_c, byb_c;

   logic [10:0] px0, px1, py0, py1;
   logic        h_arm, v_arm;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      latch    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.bomb_check) begin
               state_nx = FUSE;
               cnt_nx   = '0;
               latch    = 1'b1;
            end
         end
         FUSE: begin
            if (!bus.bomb_check) begin
               state_nx = IDLE;
            end else if (cnt == FUSE_LAST) begin
               state_nx = FIRE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         FIRE: begin
            if (!bus.bomb_check) begin
               state_nx = BLAST;
               cnt_nx   = '0;
            end
         end
         BLAST: begin
            if (cnt == BLAST_LAST) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Geometry from the live bomb position, captured on FUSE entry.
   always_comb begin
      bx     = {1'b0, bus.bombX};
      by     = {1'b0, bus.bombY};
      bx_end = bx + W_M1;
      by_end = by + H_M1;
      bx_far = bx_end + REACH;
      by_far = by_end + REACH;
      xl_c   = (bx >= REACH) ? 10'(bx - REACH) : '0;
      yt_c   = (by >= REACH) ? 10'(by - REACH) : '0;
      xr_c   = (bx_far > X_MAX) ? X_MAX[9:0]
                                : bx_far[9:0];
      yb_c   = (by_far > Y_MAX) ? Y_MAX[9:0]
                                : by_far[9:0];
      bxr_c  = (bx_end > X_MAX) ? X_MAX[9:0]
                                : bx_end[9:0];
      byb_c  = (by_end > Y_MAX) ? Y_MAX[9:0]
                                : by_end[9:0];
   end

   always_comb begin
      px0   = {1'b0, bus.playerX};
      py0   = {1'b0, bus.playerY};
      px1   = px0 + S_M1;
      py1   = py0 + S_M1;
      h_arm = (px0 <= {1'b0, xr_q})
           && (px1 >= {1'b0, xl_q})
           && (py0 <= {1'b0, byb_q})
           && (py1 >= {1'b0, byt_q});
      v_arm = (px0 <= {1'b0, bxr_q})
           && (px1 >= {1'b0, bxl_q})
           && (py0 <= {1'b0, yb_q})
           && (py1 >= {1'b0, yt_q});
      hit_nx = (state == BLAST) && (h_arm || v_arm);
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         hit_q <= 1'b0;
         xl_q  <= '0;
         xr_q  <= '0;
         yt_q  <= '0;
         yb_q  <= '0;
         bxl_q <= '0;
         bxr_q <= '0;
         byt_q <= '0;
         byb_q <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         hit_q <= hit_nx;
         if (latch) begin
            xl_q  <= xl_c;
            xr_q  <= xr_c;
            yt_q  <= yt_c;
            yb_q  <= yb_c;
            bxl_q <= bus.bombX;
            bxr_q <= bxr_c;
            byt_q <= bus.bombY;
            byb_q <= byb_c;
         end
      end
   end

   assign bus.explode      = (state == FIRE)
                           & bus.bomb_check;
   assign bus.blast_active = (state == BLAST);
   assign bus.player_hit   = hit_q;
   assign bus.blastXL      = xl_q;
   assign bus.blastXR      = xr_q;
   assign bus.blastYT      = yt_q;
   assign bus.blastYB      = yb_q;
   assign bus.blastBoxXL   = bxl_q;
   assign bus.blastBoxXR   = bxr_q;
   assign bus.blastBoxYT   = byt_q;
   assign bus.blastBoxYB   = byb_q;

endmodule

// File: tb/tb_bomb_fuse.sv
// Bench for bomb_fuse: timestamp-based reference model,
// directed scenarios and randomized traffic.
module tb_bomb_fuse;

   localparam int F = 4;
   localparam int B = 3;
   localparam int R = 48;
   localparam int W = 20;
   localparam int H = 25;
   localparam int S = 16;

   logic frame_clk = 1'b0;
   logic Reset;
   bomb_fuse_if bus ();

   bomb_fuse #(
      .FUSE_FRAMES (F),
      .BLAST_FRAMES(B),
      .BLAST_REACH (R),
      .BOMB_W      (W),
      .BOMB_H      (H),
      .PLAYER_S    (S)
   ) dut (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .bus      (bus)
   );

   always #5 frame_clk = ~frame_clk;

   int vectors = 0;
   int miscompares = 0;
   bit run_chk = 0;
   bit auto_resp = 1;
   int cyc = 0;

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
      end
   endtask

   // Reference model: timestamps of fuse start and blast
   // start rather than a state register.
   int t = 0;
   int fuse_t0 = -1;
   int blast_t0 = -1;
   bit firing = 0;
   bit m_hit = 0;
   int m_xl, m_xr, m_yt, m_yb;
   int m_bxl, m_bxr, m_byt, m_byb;

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit ov(int a0, int a1, int b0,
                             int b1, int c0, int c1,
                             int d0, int d1);
      return (a0 <= c1) && (c0 <= a1)
          && (b0 <= d1) && (d0 <= b1);
   endfunction

   task automatic clear_ext();
      m_xl = 0; m_xr = 0; m_yt = 0; m_yb = 0;
      m_bxl = 0; m_bxr = 0; m_byt = 0; m_byb = 0;
   endtask

   task automatic latch_ext(int x, int y);
      m_bxl = x;
      m_byt = y;
      m_xl  = (x >= R) ? x - R : 0;
      m_yt  = (y >= R) ? y - R : 0;
      m_xr  = imin(x + W - 1 + R, 639);
      m_yb  = imin(y + H - 1 + R, 479);
      m_bxr = imin(x + W - 1, 639);
      m_byb = imin(y + H - 1, 479);
   endtask

   initial clear_ext();

   always @(posedge frame_clk) begin : model
      int px, py;
      bit hnx;
      px  = int'(bus.playerX);
      py  = int'(bus.playerY);
      hnx = (blast_t0 >= 0) && (
            ov(px, px + S - 1, py, py + S - 1,
               m_xl, m_xr, m_byt, m_byb)
         || ov(px, px + S - 1, py, py + S - 1,
               m_bxl, m_bxr, m_yt, m_yb));
      if (Reset) begin
         fuse_t0  = -1;
         blast_t0 = -1;
         firing   = 0;
         m_hit    = 0;
         clear_ext();
      end else begin
         m_hit = hnx;
         if (blast_t0 >= 0) begin
            if (t - blast_t0 == B) blast_t0 = -1;
         end else if (firing) begin
            if (!bus.bomb_check) begin
               firing   = 0;
               blast_t0 = t;
            end
         end else if (fuse_t0 >= 0) begin
            if (!bus.bomb_check) begin
               fuse_t0 = -1;
            end else if (t - fuse_t0 == F) begin
               fuse_t0 = -1;
               firing  = 1;
            end
         end else if (bus.bomb_check) begin
            fuse_t0 = t;
            latch_ext(int'(bus.bombX), int'(bus.bombY));
         end
      end
      t++;
   end

   always @(negedge frame_clk) begin
      if (run_chk) begin
         chk("explode", int'(bus.explode),
             int'(firing && bus.bomb_check));
         chk("blast_active", int'(bus.blast_active),
             int'(blast_t0 >= 0));
         chk("player_hit", int'(bus.player_hit),
             int'(m_hit));
         chk("blastXL", int'(bus.blastXL), m_xl);
         chk("blastXR", int'(bus.blastXR), m_xr);
         chk("blastYT", int'(bus.blastYT), m_yt);
         chk("blastYB", int'(bus.blastYB), m_yb);
         chk("boxXL", int'(bus.blastBoxXL), m_bxl);
         chk("boxXR", int'(bus.blastBoxXR), m_bxr);
         chk("boxYT", int'(bus.blastBoxYT), m_byt);
         chk("boxYB", int'(bus.blastBoxYB), m_byb);
      end
   end

   // Per-scenario observations, sampled at the negedge.
   int st_c0, st_fe, st_ne, st_fb, st_nb, st_fh, st_nh;
   int l_exp, l_ba, l_hit, l_xl, l_xr, l_yt, l_yb, l_byb;

   task automatic clr_stats();
      st_c0 = cyc;
      st_fe = -1; st_ne = 0;
      st_fb = -1; st_nb = 0;
      st_fh = -1; st_nh = 0;
   endtask

   task automatic step();
      bit e;
      @(negedge frame_clk);
      e     = bus.explode;
      l_exp = int'(bus.explode);
      l_ba  = int'(bus.blast_active);
      l_hit = int'(bus.player_hit);
      l_xl  = int'(bus.blastXL);
      l_xr  = int'(bus.blastXR);
      l_yt  = int'(bus.blastYT);
      l_yb  = int'(bus.blastYB);
      l_byb = int'(bus.blastBoxYB);
      if (bus.explode) begin
         if (st_fe < 0) st_fe = cyc - st_c0;
         st_ne++;
      end
      if (bus.blast_active) begin
         if (st_fb < 0) st_fb = cyc - st_c0;
         st_nb++;
      end
      if (bus.player_hit) begin
         if (st_fh < 0) st_fh = cyc - st_c0;
         st_nh++;
      end
      @(posedge frame_clk);
      cyc++;
      #3;
      if (auto_resp && e) bus.bomb_check = 1'b0;
   endtask

   task automatic place(int x, int y);
      bus.bombX = 10'(x);
      bus.bombY = 10'(y);
      clr_stats();
      bus.bomb_check = 1'b1;
   endtask

   initial begin
      Reset = 1'b1;
      bus.bomb_check = 1'b0;
      bus.bombX = '0;
      bus.bombY = '0;
      bus.playerX = 10'd300;
      bus.playerY = 10'd300;
      clr_stats();
      @(posedge frame_clk);
      cyc++;
      #3;
      run_chk = 1;
      step();
      chk("rst_explode", l_exp, 0);
      chk("rst_blast", l_ba, 0);
      chk("rst_XR", l_xr, 0);
      Reset = 1'b0;

      // Nominal with player inside the horizontal arm.
      bus.playerX = 10'd150;
      bus.playerY = 10'd110;
      place(100, 100);
      repeat (14) step();
      chk("nom_explode_at", st_fe, 5);
      chk("nom_explode_len", st_ne, 1);
      chk("nom_blast_at", st_fb, 7);
      chk("nom_blast_len", st_nb, 3);
      chk("nom_hit_at", st_fh, 8);
      chk("nom_hit_len", st_nh, 3);
      chk("nom_XL", l_xl, 52);
      chk("nom_XR", l_xr, 167);
      chk("nom_YT", l_yt, 52);
      chk("nom_YB", l_yb, 172);

      // Player well clear of both arms.
      bus.playerX = 10'd300;
      bus.playerY = 10'd300;
      place(100, 100);
      repeat (14) step();
      chk("miss_hits", st_nh, 0);
      chk("miss_blast_len", st_nb, 3);

      // Player left edge exactly on XR.
      bus.playerX = 10'd167;
      bus.playerY = 10'd100;
      place(100, 100);
      repeat (14) step();
      chk("touch_hits", st_nh, 3);

      // Clamping near the bottom-left corner.
      place(10, 460);
      repeat (14) step();
      chk("clamp_XL", l_xl, 0);
      chk("clamp_XR", l_xr, 77);
      chk("clamp_YT", l_yt, 412);
      chk("clamp_YB", l_yb, 479);
      chk("clamp_BoxYB", l_byb, 479);

      // Bomb removed during the fuse.
      place(200, 200);
      step();
      step();
      bus.bomb_check = 1'b0;
      repeat (10) step();
      chk("abort_explode", st_ne, 0);
      chk("abort_blast", st_nb, 0);

      // Reset mid-fuse, bomb still present afterwards.
      place(120, 80);
      step();
      step();
      Reset = 1'b1;
      step();
      step();
      chk("rstf_explode", l_exp, 0);
      chk("rstf_blast", l_ba, 0);
      chk("rstf_XR", l_xr, 0);
      Reset = 1'b0;
      clr_stats();
      repeat (14) step();
      chk("rstf_explode_at", st_fe, 5);
      chk("rstf_blast_len", st_nb, 3);

      // Reset mid-blast.
      bus.playerX = 10'd130;
      bus.playerY = 10'd90;
      place(120, 80);
      for (int i = 0; i < 20 && st_nb == 0; i++) step();
      chk("rstb_reached", st_nb, 1);
      Reset = 1'b1;
      step();
      step();
      chk("rstb_blast", l_ba, 0);
      chk("rstb_hit", l_hit, 0);
      Reset = 1'b0;
      repeat (3) step();

      // Stuck responder holds FIRE.
      auto_resp = 1'b0;
      place(300, 200);
      repeat (12) step();
      chk("stuck_explode", l_exp, 1);
      chk("stuck_explode_len", st_ne, 7);
      chk("stuck_blast", st_nb, 0);
      bus.bomb_check = 1'b0;
      clr_stats();
      step();
      step();
      chk("stuck_release_blast_at", st_fb, 1);
      chk("stuck_release_explode", st_ne, 0);
      auto_resp = 1'b1;
      repeat (5) step();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int v;
         Reset = ($urandom_range(0, 99) == 0);
         auto_resp = ($urandom_range(0, 3) != 0);
         if (!bus.bomb_check) begin
            if ($urandom_range(0, 5) == 0) begin
               bus.bombX = 10'($urandom_range(0, 1023));
               bus.bombY = 10'($urandom_range(0, 1023));
               bus.bomb_check = 1'b1;
            end
         end else if ($urandom_range(0, 29) == 0) begin
            bus.bomb_check = 1'b0;
         end
         if ($urandom_range(0, 1) == 0) begin
            v = int'(bus.bombX)
              + int'($urandom_range(0, 140)) - 70;
            bus.playerX = 10'((v < 0) ? 0 : v);
            v = int'(bus.bombY)
              + int'($urandom_range(0, 140)) - 70;
            bus.playerY = 10'((v < 0) ? 0 : v);
         end else begin
            bus.playerX = 10'($urandom_range(0, 1023));
            bus.playerY = 10'($urandom_range(0, 1023));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
